sram_mix_sched: RTL and testbench

SRAM_MIX_SCHED -- requirements
Module: sram_mix_sched

---
 rtl/sram_mix_sched.sv | 246 ++++++++++++++++++++++++
 tb/tb_sram_mix_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mix_sched.sv
// sram_mix_sched: sample-tick driven scheduler for one asynchronous SRAM.
// Handles recording and playback, one 16-bit sample per audio frame.
// Defining SRAM_MIX_EN builds the mix engine. The engine averages track 2
// into track 1, one index at a time.
// Without SRAM_MIX_EN, mode 11 behaves as idle, mix_start is ignored, and
// busy and mix_done are tied low.
module sram_mix_sched #(
  parameter int ADDR_W      = 18,
  parameter int TRACK_LEN   = 128000,
  parameter int TRACK2_BASE = 128000
) (
  input  logic              clk,
  input  logic              AUD_DACLRCK,
  input  logic              sample_tick,
  input  logic [1:0]        mode,
  input  logic              mix_start,
  input  logic [15:0]       rec_sample,
  output logic [15:0]       play_sample,
  output logic              play_valid,
  output logic              busy,
  output logic              mix_done,
  output logic              overrun,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  input  logic [15:0]       sram_rdata,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_dq_oe
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REC_WR   = 3'd1,
    PLAY_RD  = 3'd2,
    PLAY_CAP = 3'd3
`ifdef SRAM_MIX_EN
    ,
    MIX_RD1  = 3'd4,
    MIX_RD2  = 3'd5,
    MIX_WR   = 3'd6,
    MIX_END  = 3'd7
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TRACK_LEN - 1);

  state_t            r_state;
  state_t            w_stateNext;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptrNext;
  logic [1:0]        r_modePrev;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addrNext;
  logic [15:0]       r_wdata;
  logic [15:0]       w_wdataNext;
  logic              r_weN;
  logic              w_weNNext;
  logic              r_oeN;
  logic              w_oeNNext;
  logic              r_dqOe;
  logic              w_dqOeNext;
  logic [15:0]       r_playSample;
  logic [15:0]       w_playSampleNext;
  logic              r_playValid;
  logic              w_playValidNext;
  logic              r_overrun;
  logic              w_overrunNext;

  logic              w_modeChanged;
  logic [ADDR_W-1:0] w_ptrCur;
  logic [ADDR_W-1:0] w_ptrInc;
  logic              w_tickActive;

`ifdef SRAM_MIX_EN
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idxNext;
  logic              r_busy;
  logic              w_busyNext;
  logic              r_mixDone;
  logic              w_mixDoneNext;
  logic [15:0]       r_track1Sample;
  logic [15:0]       w_track1SampleNext;
  logic signed [16:0] w_sum;
  logic [15:0]       w_avg;

  // The sign-extended 17-bit sum cannot overflow, so halving it always fits in 16 bits.
  assign w_sum = {r_track1Sample[15], r_track1Sample} + {sram_rdata[15], sram_rdata};
  assign w_avg = 16'(w_sum >>> 1);
  assign busy     = r_busy;
  assign mix_done = r_mixDone;
`else
  logic w_unusedMixStart;

  assign w_unusedMixStart = mix_start;
  assign busy             = 1'b0;
  assign mix_done         = 1'b0;
`endif

  // A mode change resets the pointer. A tick in that same cycle must already see address 0.
  assign w_modeChanged = (mode != r_modePrev);
  assign w_ptrCur      = w_modeChanged ? '0 : r_ptr;
  assign w_ptrInc      = (r_ptr == LAST_IDX) ? '0 : r_ptr + 1'b1;
  assign w_tickActive  = sample_tick && ((mode == 2'b01) || (mode == 2'b10));

  assign sram_addr   = r_addr;
  assign sram_wdata  = r_wdata;
  assign sram_we_n   = r_weN;
  assign sram_oe_n   = r_oeN;
  assign sram_dq_oe  = r_dqOe;
  assign play_sample = r_playSample;
  assign play_valid  = r_playValid;
  assign overrun     = r_overrun;

  // Next state plus the registered SRAM strobes for the state being entered; strobes default to released.
  always_comb begin
    w_stateNext      = r_state;
    w_ptrNext        = w_ptrCur;
    w_addrNext       = r_addr;
    w_wdataNext      = r_wdata;
    w_weNNext        = 1'b1;
    w_oeNNext        = 1'b1;
    w_dqOeNext       = 1'b0;
    w_playSampleNext = r_playSample;
    w_playValidNext  = 1'b0;
    w_overrunNext    = w_tickActive && (r_state != IDLE);
`ifdef SRAM_MIX_EN
    w_idxNext          = r_idx;
    w_busyNext         = r_busy;
    w_mixDoneNext      = 1'b0;
    w_track1SampleNext = r_track1Sample;
`endif
    case (r_state)
      IDLE: begin
        if (w_tickActive && (mode == 2'b01)) begin
          w_stateNext = REC_WR;
          w_addrNext  = w_ptrCur;
          w_wdataNext = rec_sample;
          w_weNNext   = 1'b0;
          w_dqOeNext  = 1'b1;
        end else if (w_tickActive && (mode == 2'b10)) begin
          w_stateNext = PLAY_RD;
          w_addrNext  = w_ptrCur;
          w_oeNNext   = 1'b0;
        end
`ifdef SRAM_MIX_EN
        else if ((mode == 2'b11) && mix_start) begin
          w_stateNext = MIX_RD1;
          w_busyNext  = 1'b1;
          w_idxNext   = '0;
          w_addrNext  = '0;
          w_oeNNext   = 1'b0;
        end
`endif
      end
      REC_WR: begin
        w_stateNext = IDLE;
        if (!w_modeChanged) w_ptrNext = w_ptrInc;
      end
      PLAY_RD: begin
        w_stateNext      = PLAY_CAP;
        w_playSampleNext = sram_rdata;
        w_playValidNext  = 1'b1;
        if (!w_modeChanged) w_ptrNext = w_ptrInc;
      end
      PLAY_CAP: begin
        w_stateNext = IDLE;
      end
`ifdef SRAM_MIX_EN
      MIX_RD1: begin
        w_stateNext        = MIX_RD2;
        w_track1SampleNext = sram_rdata;
        w_addrNext         = ADDR_W'(TRACK2_BASE) + r_idx;
        w_oeNNext          = 1'b0;
      end
      MIX_RD2: begin
        w_stateNext = MIX_WR;
        w_addrNext  = r_idx;
        w_wdataNext = w_avg;
        w_weNNext   = 1'b0;
        w_dqOeNext  = 1'b1;
      end
      MIX_WR: begin
        if (r_idx == LAST_IDX) begin
          w_stateNext   = MIX_END;
          w_busyNext    = 1'b0;
          w_mixDoneNext = 1'b1;
          w_ptrNext     = '0;
        end else begin
          w_stateNext = MIX_RD1;
          w_idxNext   = r_idx + 1'b1;
          w_addrNext  = r_idx + 1'b1;
          w_oeNNext   = 1'b0;
        end
      end
      MIX_END: begin
        w_stateNext = IDLE;
      end
`endif
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and output registers; reset releases the SRAM bus at once so an in-flight write never strobes.
  always_ff @(posedge clk or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      r_state        <= IDLE;
      r_ptr          <= '0;
      r_modePrev     <= 2'b00;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_weN          <= 1'b1;
      r_oeN          <= 1'b1;
      r_dqOe         <= 1'b0;
      r_playSample   <= '0;
      r_playValid    <= 1'b0;
      r_overrun      <= 1'b0;
`ifdef SRAM_MIX_EN
      r_idx          <= '0;
      r_busy         <= 1'b0;
      r_mixDone      <= 1'b0;
      r_track1Sample <= '0;
`endif
    end else begin
      r_state        <= w_stateNext;
      r_ptr          <= w_ptrNext;
      r_modePrev     <= mode;
      r_addr         <= w_addrNext;
      r_wdata        <= w_wdataNext;
      r_weN          <= w_weNNext;
      r_oeN          <= w_oeNNext;
      r_dqOe         <= w_dqOeNext;
      r_playSample   <= w_playSampleNext;
      r_playValid    <= w_playValidNext;
      r_overrun      <= w_overrunNext;
`ifdef SRAM_MIX_EN
      r_idx          <= w_idxNext;
      r_busy         <= w_busyNext;
      r_mixDone      <= w_mixDoneNext;
      r_track1Sample <= w_track1SampleNext;
`endif
    end
  end

endmodule

// File: tb/tb_sram_mix_sched.sv
`timescale 1ns/1ps
// tb_sram_mix_sched: randomized scoreboard bench for sram_mix_sched.
// Uses a behavioural SRAM and a reference model built on queues.
module tb_sram_mix_sched;

  localparam int ADDR_W      = 4;
  localparam int TRACK_LEN   = 4;
  localparam int TRACK2_BASE = 8;
  localparam int MEM_DEPTH   = 1 << ADDR_W;

  logic              clk         = 1'b0;
  logic              AUD_DACLRCK = 1'b1;
  logic              sample_tick = 1'b0;
  logic [1:0]        mode        = 2'b00;
  logic              mix_start   = 1'b0;
  logic [15:0]       rec_sample  = 16'h0;
  logic [15:0]       play_sample;
  logic              play_valid;
  logic              busy;
  logic              mix_done;
  logic              overrun;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_wdata;
  logic [15:0]       sram_rdata;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic              sram_dq_oe;

  logic [15:0]       mem [MEM_DEPTH];
  logic              preEn   = 1'b0;
  logic [ADDR_W-1:0] preAddr = '0;
  logic [15:0]       preData = 16'h0;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [15:0]       old;
  } wr_t;
  typedef struct {
    int          cyc;
    logic [15:0] data;
  } play_t;

  wr_t   wrQ[$];
  play_t playQ[$];
  int    ovQ[$];
  int    doneQ[$];

  int          checks      = 0;
  int          failures    = 0;
  int          cyc         = 0;
  int          ptrM        = 0;
  int          busyUntil   = 0;
  int          mixStartCyc = -100;
  logic [15:0] refMem [MEM_DEPTH];
  logic [15:0] monLastPlay = 16'h0;

  sram_mix_sched #(
    .ADDR_W(ADDR_W),
    .TRACK_LEN(TRACK_LEN),
    .TRACK2_BASE(TRACK2_BASE)
  ) dut (
    .clk(clk),
    .AUD_DACLRCK(AUD_DACLRCK),
    .sample_tick(sample_tick),
    .mode(mode),
    .mix_start(mix_start),
    .rec_sample(rec_sample),
    .play_sample(play_sample),
    .play_valid(play_valid),
    .busy(busy),
    .mix_done(mix_done),
    .overrun(overrun),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n),
    .sram_dq_oe(sram_dq_oe)
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp expected and observed events.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: combinational read while OE is low, write at the edge closing a WE-low cycle.
  assign sram_rdata = sram_oe_n ? 16'h0 : mem[sram_addr];
  always @(posedge clk) begin
    if (preEn) mem[preAddr] <= preData;
    else if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_wdata;
  end

  function automatic void checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, actual, expected, cyc);
    end
  endfunction

  // Monitor: pop the scoreboard whenever the DUT presents an event, and check per-cycle invariants.
  always @(negedge clk) begin : monitor
    wr_t   mw;
    play_t mp;
    int    mc;
    if (AUD_DACLRCK) begin
      monLastPlay = 16'h0;
    end else begin
      checkOutput("dq_oe_tracks_we", 32'(sram_dq_oe), 32'(!sram_we_n));
      checkOutput("oe_we_exclusive", 32'(!sram_we_n && !sram_oe_n), 32'd0);
      checkOutput("busy_window", 32'(busy), 32'((cyc > mixStartCyc) && (cyc <= mixStartCyc + 3 * TRACK_LEN)));
      if (!sram_we_n) begin
        checkOutput("write_expected", 32'(wrQ.size() != 0), 32'd1);
        if (wrQ.size() != 0) begin
          mw = wrQ.pop_front();
          checkOutput("write_cycle", cyc, mw.cyc);
          checkOutput("write_addr", 32'(sram_addr), 32'(mw.addr));
          checkOutput("write_data", 32'(sram_wdata), 32'(mw.data));
        end
      end
      if (play_valid) begin
        checkOutput("play_expected", 32'(playQ.size() != 0), 32'd1);
        if (playQ.size() != 0) begin
          mp = playQ.pop_front();
          monLastPlay = mp.data;
          checkOutput("play_cycle", cyc, mp.cyc);
          checkOutput("play_sample", 32'(play_sample), 32'(mp.data));
        end
      end else begin
        checkOutput("play_hold", 32'(play_sample), 32'(monLastPlay));
      end
      if (overrun) begin
        checkOutput("overrun_expected", 32'(ovQ.size() != 0), 32'd1);
        if (ovQ.size() != 0) begin
          mc = ovQ.pop_front();
          checkOutput("overrun_cycle", cyc, mc);
        end
      end
      if (mix_done) begin
        checkOutput("mix_done_expected", 32'(doneQ.size() != 0), 32'd1);
        if (doneQ.size() != 0) begin
          mc = doneQ.pop_front();
          checkOutput("mix_done_cycle", cyc, mc);
        end
      end
    end
  end

  // Drive one cycle of inputs and push the model's predicted responses.
  task automatic applyStimulus(input logic tick, input logic start, input logic [15:0] smp);
    int  t;
    wr_t w;
    t           = cyc;
    sample_tick = tick;
    mix_start   = start;
    rec_sample  = smp;
    if (tick && (mode == 2'b01 || mode == 2'b10)) begin
      if (t > busyUntil) begin
        if (mode == 2'b01) begin
          w.cyc  = t + 1;
          w.addr = ADDR_W'(ptrM);
          w.data = smp;
          w.old  = refMem[ptrM];
          wrQ.push_back(w);
          refMem[ptrM] = smp;
          busyUntil = t + 1;
        end else begin
          playQ.push_back('{t + 2, refMem[ptrM]});
          busyUntil = t + 2;
        end
        ptrM = (ptrM + 1) % TRACK_LEN;
      end else begin
        ovQ.push_back(t + 1);
      end
    end
`ifdef SRAM_MIX_EN
    if (start && mode == 2'b11 && t > busyUntil) begin
      for (int i = 0; i < TRACK_LEN; i++) begin
        int s;
        s = (int'($signed(refMem[i])) + int'($signed(refMem[TRACK2_BASE + i]))) >>> 1;
        w.cyc  = t + 3 + 3 * i;
        w.addr = ADDR_W'(i);
        w.data = s[15:0];
        w.old  = refMem[i];
        wrQ.push_back(w);
        refMem[i] = s[15:0];
      end
      doneQ.push_back(t + 1 + 3 * TRACK_LEN);
      busyUntil   = t + 1 + 3 * TRACK_LEN;
      mixStartCyc = t;
      ptrM        = 0;
    end
`endif
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    mix_start   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 16'h0);
  endtask

  task automatic setMode(input logic [1:0] m);
    if (m != mode) ptrM = 0;
    mode = m;
    applyStimulus(1'b0, 1'b0, 16'h0);
  endtask

  task automatic preload(input int a, input logic [15:0] d);
    preEn     = 1'b1;
    preAddr   = ADDR_W'(a);
    preData   = d;
    refMem[a] = d;
    @(posedge clk);
    #1;
    preEn = 1'b0;
  endtask

  // Assert reset mid-cycle, check outputs immediately, and discard accesses that can no longer happen.
  task automatic doReset();
    AUD_DACLRCK = 1'b1;
    #1;
    checkOutput("rst_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("rst_oe_n", 32'(sram_oe_n), 32'd1);
    checkOutput("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    checkOutput("rst_addr", 32'(sram_addr), 32'd0);
    checkOutput("rst_wdata", 32'(sram_wdata), 32'd0);
    checkOutput("rst_play_sample", 32'(play_sample), 32'd0);
    checkOutput("rst_play_valid", 32'(play_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mix_done", 32'(mix_done), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    for (int i = wrQ.size() - 1; i >= 0; i--) refMem[wrQ[i].addr] = wrQ[i].old;
    wrQ.delete();
    playQ.delete();
    ovQ.delete();
    doneQ.delete();
    ptrM        = 0;
    mixStartCyc = -100;
    @(posedge clk);
    @(posedge clk);
    #1;
    AUD_DACLRCK = 1'b0;
    busyUntil   = cyc - 1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    doReset();
    for (int i = 0; i < MEM_DEPTH; i++) preload(i, 16'($urandom));

    $display("[TB] record five ticks across the wrap");
    setMode(2'b01);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 1'b0, 16'(16'h0011 * i));
      idle(2);
    end

    $display("[TB] back-to-back record ticks");
    applyStimulus(1'b1, 1'b0, 16'hA5A5);
    applyStimulus(1'b1, 1'b0, 16'h5A5A);
    idle(3);

    $display("[TB] directed playback from address 0");
    setMode(2'b00);
    preload(0, 16'h1234);
    setMode(2'b10);
    applyStimulus(1'b1, 1'b0, 16'h0);
    idle(3);

    $display("[TB] randomized record/play traffic");
    for (int r = 0; r < 6; r++) begin
      setMode(2'($urandom_range(0, 3)));
      for (int k = 0; k < 12; k++) begin
        idle($urandom_range(0, 3));
        applyStimulus(1'b1, 1'b0, 16'($urandom));
      end
      idle(3);
    end

`ifdef SRAM_MIX_EN
    $display("[TB] directed mix of signed extremes");
    setMode(2'b00);
    preload(0, 16'h7FFF);
    preload(1, 16'h8000);
    preload(2, 16'h0002);
    preload(3, 16'hFFFF);
    preload(TRACK2_BASE + 0, 16'h7FFF);
    preload(TRACK2_BASE + 1, 16'h8000);
    preload(TRACK2_BASE + 2, 16'hFFFE);
    preload(TRACK2_BASE + 3, 16'h0001);
    setMode(2'b11);
    applyStimulus(1'b0, 1'b1, 16'h0);
    idle(4);
    applyStimulus(1'b0, 1'b1, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    idle(12);
    checkOutput("mix_track1_0", 32'(mem[0]), 32'h7FFF);
    checkOutput("mix_track1_1", 32'(mem[1]), 32'h8000);
    checkOutput("mix_track1_2", 32'(mem[2]), 32'h0000);
    checkOutput("mix_track1_3", 32'(mem[3]), 32'h0000);

    $display("[TB] reset during the second read of a mix");
    for (int i = 0; i < TRACK_LEN; i++) preload(TRACK2_BASE + i, 16'($urandom));
    applyStimulus(1'b0, 1'b1, 16'h0);
    idle(1);
    doReset();
    idle(2);
    for (int i = 0; i < TRACK_LEN; i++) checkOutput("mix_abort_track1", 32'(mem[i]), 32'(refMem[i]));
    setMode(2'b01);
    applyStimulus(1'b1, 1'b0, 16'h4321);
    idle(3);
`else
    $display("[TB] mix request without the mix engine");
    setMode(2'b11);
    applyStimulus(1'b0, 1'b1, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h7777);
    for (int i = 0; i < 6; i++) begin
      checkOutput("nomix_busy", 32'(busy), 32'd0);
      checkOutput("nomix_mix_done", 32'(mix_done), 32'd0);
      checkOutput("nomix_we_n", 32'(sram_we_n), 32'd1);
      checkOutput("nomix_oe_n", 32'(sram_oe_n), 32'd1);
      idle(1);
    end
`endif

    $display("[TB] reset during a record write");
    setMode(2'b01);
    idle(2);
    applyStimulus(1'b1, 1'b0, 16'hBEEF);
    doReset();
    applyStimulus(1'b1, 1'b0, 16'hCAFE);
    idle(20);

    checkOutput("drain_writes", 32'(wrQ.size()), 32'd0);
    checkOutput("drain_plays", 32'(playQ.size()), 32'd0);
    checkOutput("drain_overruns", 32'(ovQ.size()), 32'd0);
    checkOutput("drain_mix_done", 32'(doneQ.size()), 32'd0);
    for (int i = 0; i < MEM_DEPTH; i++) checkOutput("mem_final", 32'(mem[i]), 32'(refMem[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
